r4booth_share_ctrl: RTL and testbench



---
 rtl/nla_mul_pkg.sv | 34 +++
 rtl/r4booth_share_ctrl_rr_arbiter.sv | 40 ++++
 rtl/r4booth_share_ctrl.sv | 128 ++++++++++++
 tb/tb_r4booth_share_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_mul_pkg.sv
// Shared constants and tag type for the Booth multiplier sharing logic.
// Every requester ID fits the 3-bit tag field, so NREQ is limited to NREQ_MAX.
package nla_mul_pkg;

    localparam int N        = 13;
    localparam int MUL_LAT  = 4;
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: 3'd0};

    // Converts a one-hot (or all-zero) vector to its bit index; zero maps to ID 0.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NREQ_MAX-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            id = oh[i] ? ID_W'(i) : id;
        end
        return id;
    endfunction

    // Round-robin successor of a granted ID, wrapping modulo nreq.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g, input int nreq);
        logic [ID_W-1:0] nxt;
        nxt = (int'(g) >= nreq - 1) ? 3'd0 : g + 3'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/r4booth_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester
// at or after rr_ptr, wrapping modulo NREQ; no grant while en is low.
module rr_arbiter
    import nla_mul_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] elig,
    input  logic [ID_W-1:0] rr_ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    int dist_s [NREQ];
    int best_s;

    // Distance of each requester from the pointer in round-robin order.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dist_s[i] = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NREQ - int'(rr_ptr));
        end
    end

    // Smallest distance among eligible requesters; NREQ means none is eligible.
    always_comb begin
        best_s = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            best_s = (elig[i] && (dist_s[i] < best_s)) ? dist_s[i] : best_s;
        end
    end

    // Distances are unique, so at most one bit matches the winner.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = en && elig[i] && (dist_s[i] == best_s);
        end
    end

endmodule

// File: rtl/r4booth_share_ctrl.sv
// Shares one pipelined radix-4 Booth multiplier among NREQ requesters; a tag
// pipe matched to the multiplier latency routes each product back to its owner.
module r4booth_share_ctrl
    import nla_mul_pkg::*;
#(
    parameter int N       = nla_mul_pkg::N,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = nla_mul_pkg::MUL_LAT
) (
    input  logic              clkn_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*N-1:0] req_a_i,
    input  logic [NREQ*N-1:0] req_b_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [2*N-1:0]    rsp_data_o,
    output logic [N-1:0]      mul_a_o,
    output logic [N-1:0]      mul_b_o,
    input  logic [2*N-1:0]    mul_prod_i,
    output logic              busy_o,
    output logic [15:0]       issue_cnt_o
);

    localparam int STAGES = MUL_LAT - 1;

    logic [NREQ-1:0] pend_r;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] rsp_valid_s;
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] grant_id_s;
    logic            grant_en_s;
    logic            hs_s;
    logic [N-1:0]    mul_a_s;
    logic [N-1:0]    mul_b_s;
    logic [15:0]     issue_cnt_r;
    tag_t            tag_r [STAGES];
    tag_t            tag_last_s;
    logic            busy_s;

    assign elig_s     = req_valid_i & ~pend_r;
    // No grant is offered while reset is held, so ready reads 0 in reset.
    assign grant_en_s = en_i & ~rst_i;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .elig   (elig_s),
        .rr_ptr (rr_ptr_r),
        .en     (grant_en_s),
        .grant  (grant_s)
    );

    // Grants only go to valid requesters, so any grant is a handshake.
    assign hs_s       = |grant_s;
    assign grant_id_s = onehot_to_id(NREQ_MAX'(grant_s));

    // Operand mux: grant is one-hot, so OR-ing masked operands selects one.
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            mul_a_s = mul_a_s | (req_a_i[i*N +: N] & {N{grant_s[i]}});
            mul_b_s = mul_b_s | (req_b_i[i*N +: N] & {N{grant_s[i]}});
        end
    end

    assign tag_last_s = tag_r[STAGES-1];

    // Decode the emerging tag into the one-hot response strobe.
    always_comb begin
        rsp_valid_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_s[i] = tag_last_s.valid && (tag_last_s.id == ID_W'(i));
        end
    end

    // Busy whenever any tag stage holds an operation in flight.
    always_comb begin
        busy_s = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy_s = busy_s | tag_r[s].valid;
        end
    end

    // Pending bits, round-robin pointer and handshake counter.
    always_ff @(negedge clkn_i or posedge rst_i) begin
        if (rst_i) begin
            pend_r      <= '0;
            rr_ptr_r    <= '0;
            issue_cnt_r <= 16'd0;
        end else begin
            pend_r <= (pend_r & ~rsp_valid_s) | grant_s;
            if (hs_s) begin
                rr_ptr_r    <= next_ptr(grant_id_s, NREQ);
                issue_cnt_r <= issue_cnt_r + 16'd1;
            end else begin
                rr_ptr_r    <= rr_ptr_r;
                issue_cnt_r <= issue_cnt_r;
            end
        end
    end

    // Tag pipe, latency-matched so the tag exits with its product.
    always_ff @(negedge clkn_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                tag_r[s] <= TAG_IDLE;
            end
        end else begin
            tag_r[0] <= hs_s ? tag_t'{valid: 1'b1, id: grant_id_s} : TAG_IDLE;
            for (int s = 1; s < STAGES; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    assign req_ready_o = grant_s;
    assign mul_a_o     = mul_a_s;
    assign mul_b_o     = mul_b_s;
    assign rsp_valid_o = rsp_valid_s;
    assign rsp_data_o  = tag_last_s.valid ? mul_prod_i : '0;
    assign busy_o      = busy_s;
    assign issue_cnt_o = issue_cnt_r;

endmodule

// File: tb/tb_r4booth_share_ctrl.sv
// Self-checking bench for r4booth_share_ctrl with a 3-register multiplier
// model, directed vector tables, hand sequences and a randomized model run.
module tb_r4booth_share_ctrl;

    localparam int N    = 13;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic              clkn = 1'b1;
    logic              rst  = 1'b1;
    logic              en   = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*N-1:0]    rsp_data;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [2*N-1:0]    mul_prod;
    logic              busy;
    logic [15:0]       issue_cnt;

    logic [N-1:0]   opa [NREQ];
    logic [N-1:0]   opb [NREQ];
    logic [2*N-1:0] p0, p1, p2;

    int tests = 0;
    int fails = 0;

    r4booth_share_ctrl #(.N(N), .NREQ(NREQ), .MUL_LAT(4)) dut (
        .clkn_i      (clkn),
        .rst_i       (rst),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_prod_i  (mul_prod),
        .busy_o      (busy),
        .issue_cnt_o (issue_cnt)
    );

    always #5 clkn = ~clkn;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = opa[i];
            req_b[i*N +: N] = opb[i];
        end
    end

    // External multiplier: product visible three cycles after operand capture.
    always @(negedge clkn or posedge rst) begin
        if (rst) begin
            p0 <= '0; p1 <= '0; p2 <= '0;
        end else begin
            p0 <= {13'd0, mul_a} * {13'd0, mul_b};
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign mul_prod = p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: per-requester due cycle (-1 = idle) and product.
    int             m_cyc;
    int             m_ptr;
    int             m_due [NREQ];
    logic [2*N-1:0] m_prod [NREQ];
    logic [15:0]    m_cnt;
    logic [NREQ-1:0] m_last_grant;

    task automatic model_reset();
        m_cyc = 0; m_ptr = 0; m_cnt = 16'd0; m_last_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            m_due[k] = -1; m_prod[k] = '0;
        end
    endtask

    task automatic step();
        int g;
        int k;
        logic [NREQ-1:0] e_rdy, e_rv;
        logic [2*N-1:0]  e_d;
        logic [N-1:0]    e_a, e_b;
        logic            e_busy;
        @(posedge clkn);
        g = -1;
        if (en) begin
            for (int j = 0; j < NREQ; j++) begin
                k = (m_ptr + j) % NREQ;
                if (g < 0 && req_valid[k] && m_due[k] < 0) g = k;
            end
        end
        e_rdy = '0; e_a = '0; e_b = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1; e_a = opa[g]; e_b = opb[g];
        end
        e_rv = '0; e_d = '0; e_busy = 1'b0;
        for (int q = 0; q < NREQ; q++) begin
            if (m_due[q] == m_cyc) begin e_rv[q] = 1'b1; e_d = m_prod[q]; end
            if (m_due[q] >= m_cyc) e_busy = 1'b1;
        end
        chk("m_ready", 32'(req_ready), 32'(e_rdy));
        chk("m_mul_a", 32'(mul_a), 32'(e_a));
        chk("m_mul_b", 32'(mul_b), 32'(e_b));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("m_rsp_data", 32'(rsp_data), 32'(e_d));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_cnt", 32'(issue_cnt), 32'(m_cnt));
        for (int q = 0; q < NREQ; q++) begin
            if (m_due[q] == m_cyc) m_due[q] = -1;
        end
        if (g >= 0) begin
            m_due[g]  = m_cyc + LAT;
            m_prod[g] = {13'd0, opa[g]} * {13'd0, opb[g]};
            m_ptr     = (g + 1) % NREQ;
            m_cnt     = m_cnt + 16'd1;
        end
        m_last_grant = e_rdy;
        m_cyc++;
        @(negedge clkn); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; req_valid = '0;
        model_reset();
        @(negedge clkn); #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic           rst_before;
        logic [3:0]     valid;
        logic           en;
        logic [3:0]     ready;
        logic [3:0]     rsp_v;
        logic [2*N-1:0] rsp_d;
        logic           busy;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        // All four requesters valid: strict rotation, products i+1 times 10.
        vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 26'd0,  1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0000, 26'd0,  1'b1};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0000, 26'd0,  1'b1};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0001, 26'd10, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0010, 26'd20, 1'b1};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 26'd30, 1'b1};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b1000, 26'd40, 1'b1};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0001, 26'd10, 1'b1};
        // Requesters 0 and 3 with en low in cycles 1-2: pointer held at 1.
        vecs[8]  = '{1'b1, 4'b1001, 1'b1, 4'b0001, 4'b0000, 26'd0,  1'b0};
        vecs[9]  = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 26'd0,  1'b1};
        vecs[10] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 26'd0,  1'b1};
        vecs[11] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 4'b0001, 26'd10, 1'b1};
        vecs[12] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 4'b0000, 26'd0,  1'b1};
        vecs[13] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 26'd0,  1'b1};
        vecs[14] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b1000, 26'd40, 1'b1};
        vecs[15] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 4'b0001, 26'd10, 1'b1};

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = N'(i + 1); opb[i] = 13'd10;
        end

        for (int v = 0; v < 16; v++) begin
            if (vecs[v].rst_before) do_reset();
            req_valid = vecs[v].valid;
            en        = vecs[v].en;
            @(posedge clkn);
            ea = '0; eb = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (vecs[v].ready[i]) begin ea = N'(i + 1); eb = 13'd10; end
            end
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].ready));
            chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].rsp_v));
            chk($sformatf("vec%0d_rsp_data", v), 32'(rsp_data), 32'(vecs[v].rsp_d));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            chk($sformatf("vec%0d_mul_a", v), 32'(mul_a), 32'(ea));
            chk($sformatf("vec%0d_mul_b", v), 32'(mul_b), 32'(eb));
            @(negedge clkn); #1;
        end

        // Single request from requester 2 with the largest multiplicand.
        do_reset();
        opa[2] = 13'h1FFF; opb[2] = 13'h0003;
        req_valid = 4'b0100;
        @(posedge clkn);
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_mul_a", 32'(mul_a), 32'h1FFF);
        chk("single_mul_b", 32'(mul_b), 32'h3);
        chk("single_busy0", 32'(busy), 32'd0);
        @(negedge clkn); #1;
        req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clkn);
            chk($sformatf("single_busy%0d", c), 32'(busy), (c <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("single_rsp_valid%0d", c), 32'(rsp_valid), (c == 3) ? 32'h4 : 32'd0);
            chk($sformatf("single_rsp_data%0d", c), 32'(rsp_data), (c == 3) ? 32'h05FFD : 32'd0);
            @(negedge clkn); #1;
        end
        chk("single_cnt", 32'(issue_cnt), 32'd1);

        // Lone requester 1 held valid: pending mask spaces grants 4 cycles apart.
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            @(posedge clkn);
            chk($sformatf("pend_ready_c%0d", c), 32'(req_ready), (c % 4 == 0) ? 32'h2 : 32'd0);
            @(negedge clkn); #1;
        end

        // Reset in cycle 2 after two issues: in-flight products are dropped.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = N'(i + 1); opb[i] = 13'd10;
        end
        req_valid = 4'b1111;
        @(posedge clkn);
        chk("rmid_ready0", 32'(req_ready), 32'h1);
        @(negedge clkn); #1;
        @(posedge clkn);
        chk("rmid_ready1", 32'(req_ready), 32'h2);
        @(negedge clkn); #1;
        rst = 1'b1;
        @(posedge clkn);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_cnt", 32'(issue_cnt), 32'd0);
        chk("rmid_ready", 32'(req_ready), 32'd0);
        @(negedge clkn); #1;
        rst = 1'b0; req_valid = '0;
        for (int c = 3; c < 8; c++) begin
            @(posedge clkn);
            chk($sformatf("rmid_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("rmid_busy_c%0d", c), 32'(busy), 32'd0);
            @(negedge clkn); #1;
        end
        opa[0] = 13'd5; opb[0] = 13'd7; req_valid = 4'b0001;
        @(posedge clkn);
        chk("rmid_fresh_ready", 32'(req_ready), 32'h1);
        @(negedge clkn); #1;
        req_valid = '0;
        repeat (2) begin @(negedge clkn); #1; end
        @(posedge clkn);
        chk("rmid_fresh_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rmid_fresh_rsp_data", 32'(rsp_data), 32'd35);
        @(negedge clkn); #1;
        chk("rmid_fresh_cnt", 32'(issue_cnt), 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || m_last_grant[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[k] = 1'b1;
                        opa[k] = ($urandom_range(0, 7) == 0) ? 13'h1FFF : N'($urandom);
                        opb[k] = ($urandom_range(0, 7) == 0) ? 13'h1FFF : N'($urandom);
                    end else begin
                        req_valid[k] = 1'b0;
                    end
                end
            end
            en = ($urandom_range(0, 7) != 0);
            step();
        end

        // Counter wrap: one issue per cycle with all four requesters valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = N'(3 * i + 1); opb[i] = 13'h1FFF;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 65535; c++) step();
        @(posedge clkn);
        chk("wrap_cnt_ffff", 32'(issue_cnt), 32'h0000FFFF);
        chk("wrap_ready", 32'(req_ready), 32'h8);
        @(negedge clkn); #1;
        @(posedge clkn);
        chk("wrap_cnt_zero", 32'(issue_cnt), 32'd0);
        @(negedge clkn); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
